// File: rtl/afifo_pop_streamer.sv
// Read-side FIFO consumer: pops while credit allows, captures DataOut one cycle later,
// and presents words on a valid/ready stream through a 2-entry skid buffer.
module afifo_pop_streamer #(
    parameter int DataSize   = 3,
    parameter int CountWidth = 16
) (
    input  logic                  Rclk,
    input  logic                  Rreset,
    input  logic                  Enable,
    input  logic                  empty,
    input  logic [DataSize-1:0]   DataOut,
    output logic                  Pop,
    output logic [DataSize-1:0]   StreamData,
    output logic                  StreamValid,
    input  logic                  StreamReady,
    output logic [CountWidth-1:0] PopCount,
    output logic                  Busy
);

    logic [1:0]          occ;
    logic                inflight;
    logic                valid_q;
    logic [DataSize-1:0] head_q;
    logic [DataSize-1:0] tail_q;
    logic                hs;
    logic [2:0]          credit;
    logic [1:0]          occ_next;

    // credit is next-cycle occupancy; counting hs lets Pop restart on the handshake cycle
    always_comb begin
        hs       = valid_q & StreamReady;
        credit   = {1'b0, occ} + {2'b00, inflight} - {2'b00, hs};
        occ_next = credit[1:0];
        Pop      = Enable & ~empty & ~Rreset & (credit < 3'd2);
    end

    assign StreamValid = valid_q;
    assign StreamData  = head_q;
    assign Busy        = valid_q | inflight;

    always_ff @(posedge Rclk) begin
        if (Rreset) begin
            occ      <= '0;
            inflight <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            PopCount <= '0;
        end else begin
            occ      <= occ_next;
            valid_q  <= (occ_next != 2'd0);
            inflight <= Pop;
            if (Pop)
                PopCount <= PopCount + {{(CountWidth-1){1'b0}}, 1'b1};
            // head is always entry 0; a departing head is refilled from tail or the capture
            case ({inflight, hs})
                2'b10: begin
                    if (occ == 2'd0)
                        head_q <= DataOut;
                    else
                        tail_q <= DataOut;
                end
                2'b01: head_q <= tail_q;
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= DataOut;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= DataOut;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_pop_streamer.sv
// Directed bench for afifo_pop_streamer: FIFO model feeds the DUT, a scoreboard queue
// holds words in push order and a negedge monitor checks occupancy, Pop and delivery.
module tb_afifo_pop_streamer;

    logic        Rclk = 1'b0;
    logic        Rreset;
    logic        Enable;
    logic        empty;
    logic [2:0]  DataOut = '0;
    logic        Pop;
    logic [2:0]  StreamData;
    logic        StreamValid;
    logic        StreamReady;
    logic [15:0] PopCount;
    logic        Busy;

    logic        w_pop;
    logic [2:0]  w_data;
    logic        w_valid;
    logic [1:0]  w_popcount;
    logic        w_busy;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [2:0] fifo_mem [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [2:0] exp_q [$];

    int   occ_m   = 0;
    int   infl_m  = 0;
    int   pc_m    = 0;
    logic stall_m = 1'b0;
    logic prev_rst = 1'b1;
    logic [2:0] held_m = '0;

    always #5 Rclk = ~Rclk;

    afifo_pop_streamer #(.DataSize(3), .CountWidth(16)) u_dut (
        .Rclk(Rclk), .Rreset(Rreset), .Enable(Enable), .empty(empty), .DataOut(DataOut),
        .Pop(Pop), .StreamData(StreamData), .StreamValid(StreamValid),
        .StreamReady(StreamReady), .PopCount(PopCount), .Busy(Busy)
    );

    // narrow counter copy sharing all inputs, used to observe PopCount wrap
    afifo_pop_streamer #(.DataSize(3), .CountWidth(2)) u_wrap (
        .Rclk(Rclk), .Rreset(Rreset), .Enable(Enable), .empty(empty), .DataOut(DataOut),
        .Pop(w_pop), .StreamData(w_data), .StreamValid(w_valid),
        .StreamReady(StreamReady), .PopCount(w_popcount), .Busy(w_busy)
    );

    assign empty = (wr_ptr == rd_ptr);

    always @(posedge Rclk) begin
        if (Pop) begin
            DataOut <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    always @(negedge Rclk) begin
        int   nxt;
        int   drop;
        logic hs_m;
        logic exp_pop;
        logic [2:0] w;
        hs_m = (occ_m != 0) && StreamReady;
        chk("valid", StreamValid, occ_m != 0);
        chk("busy", Busy, (occ_m != 0) || (infl_m != 0));
        nxt = occ_m + infl_m - int'(hs_m);
        chk("occ_bound", (nxt >= 0) && (nxt <= 2), 1);
        exp_pop = Enable && !empty && !Rreset && (nxt < 2);
        chk("pop", Pop, exp_pop);
        chk("wrap_pop", w_pop, exp_pop);
        chk("popcount", PopCount, pc_m % 65536);
        chk("wrap_popcount", w_popcount, pc_m % 4);
        if (stall_m && !prev_rst)
            chk("stall_hold", StreamData, held_m);
        if (hs_m) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("sb_data", StreamData, w);
            end
        end
        stall_m  = (occ_m != 0) && !StreamReady;
        held_m   = StreamData;
        prev_rst = Rreset;
        if (Rreset) begin
            drop = occ_m + infl_m - int'(hs_m);
            for (int i = 0; i < drop; i++)
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            occ_m  = 0;
            infl_m = 0;
            pc_m   = 0;
        end else begin
            occ_m  = nxt;
            infl_m = int'(exp_pop);
            if (exp_pop) pc_m++;
        end
    end

    initial begin
        int npop;
        Rreset      = 1'b1;
        Enable      = 1'b1;
        StreamReady = 1'b1;
        push(3'd5); push(3'd2); push(3'd7);

        // reset with data available
        repeat (2) begin
            @(negedge Rclk);
            chk("rst_pop", Pop, 0);
        end
        @(posedge Rclk); #1;
        Rreset = 1'b0;
        @(negedge Rclk);
        chk("rst_valid", StreamValid, 0);
        chk("rst_data", StreamData, 0);
        chk("rst_popcount", PopCount, 0);
        chk("rst_busy", Busy, 0);
        chk("first_pop", Pop, 1);

        // streaming 5,2,7
        @(negedge Rclk); chk("s1_pop", Pop, 1); chk("s1_valid", StreamValid, 0);
        @(negedge Rclk); chk("s2_pop", Pop, 1); chk("s2_data", StreamData, 5);
        @(negedge Rclk); chk("s3_pop", Pop, 0); chk("s3_data", StreamData, 2);
        @(negedge Rclk); chk("s4_data", StreamData, 7); chk("s4_valid", StreamValid, 1);
        @(negedge Rclk); chk("s5_valid", StreamValid, 0); chk("s5_popcount", PopCount, 3);
        chk("s5_wrapcount", w_popcount, 3);

        // backpressure with 1..6
        @(posedge Rclk); #1;
        StreamReady = 1'b0;
        for (int v = 1; v <= 6; v++) push(3'(v));
        npop = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Rclk);
            if (Pop) npop++;
            if (StreamValid) chk("bp_hold", StreamData, 1);
        end
        chk("bp_pops", npop, 2);
        chk("bp_valid", StreamValid, 1);
        @(posedge Rclk); #1;
        StreamReady = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            @(negedge Rclk);
            chk("bp_steady_valid", StreamValid, 1);
            chk("bp_steady_data", StreamData, v);
        end
        @(negedge Rclk);
        chk("bp_drained", StreamValid, 0);
        chk("bp_popcount", PopCount, 9);
        chk("bp_wrapcount", w_popcount, 1);

        // Enable drop with 4 in flight
        @(posedge Rclk); #1;
        push(3'd4);
        @(negedge Rclk); chk("en_pop", Pop, 1);
        @(posedge Rclk); #1;
        Enable = 1'b0;
        push(3'd3);
        @(negedge Rclk); chk("en_off_pop", Pop, 0); chk("en_busy", Busy, 1);
        @(negedge Rclk); chk("en_data", StreamData, 4); chk("en_valid", StreamValid, 1);
        @(negedge Rclk); chk("en_busy_fall", Busy, 0);
        repeat (3) begin
            @(negedge Rclk);
            chk("en_off_nopop", Pop, 0);
        end

        // drain the held word, then sit on an empty FIFO
        @(posedge Rclk); #1;
        Enable = 1'b1;
        repeat (6) @(negedge Rclk);
        for (int i = 0; i < 20; i++) begin
            @(negedge Rclk);
            chk("empty_pop", Pop, 0);
            chk("empty_valid", StreamValid, 0);
        end

        // reset with the buffer full
        @(posedge Rclk); #1;
        StreamReady = 1'b0;
        push(3'd6); push(3'd5); push(3'd4);
        repeat (4) @(negedge Rclk);
        chk("mr_full_data", StreamData, 6);
        chk("mr_full_valid", StreamValid, 1);
        @(posedge Rclk); #1;
        Rreset = 1'b1;
        @(negedge Rclk); chk("mr_pop", Pop, 0);
        @(posedge Rclk); #1;
        Rreset      = 1'b0;
        StreamReady = 1'b1;
        @(negedge Rclk);
        chk("mr_valid", StreamValid, 0);
        chk("mr_busy", Busy, 0);
        chk("mr_pop_again", Pop, 1);
        @(negedge Rclk); chk("mr_inflight_valid", StreamValid, 0);
        @(negedge Rclk); chk("mr_fresh_data", StreamData, 4); chk("mr_fresh_valid", StreamValid, 1);
        repeat (3) @(negedge Rclk);
        chk("end_sb_empty", exp_q.size(), 0);
        chk("end_fifo_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
